// File: rtl/line_buffer_pkg.sv
// Shared definitions for the KxK line buffer.
//   - lb_state_e     : frame sequencing states
//   - lb_num_banks   : line banks in the ring (K+1)
//   - lb_beat_w      : bits in one input pixel (DWIDTH*P_CH)
//   - lb_pad_rows    : rows of same-padding above/below ((K-1)/2)
//   - lb_cfg_legal   : frame geometry check applied when a config is offered
package line_buffer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } lb_state_e;

   localparam int LB_MIN_K = 3;
   localparam int LB_MAX_K = 7;
   localparam int LB_CNT_W = 8;

   function automatic int lb_num_banks(input int k);
      return k + 1;
   endfunction

   function automatic int lb_beat_w(input int dw, input int pch);
      return dw * pch;
   endfunction

   function automatic int lb_pad_rows(input int k);
      return (k - 1) / 2;
   endfunction

   // Width must be 1..max_w; height must cover one full kernel, or with
   // padding at least one row.
   function automatic logic lb_cfg_legal(input logic [7:0] w, input logic [7:0] h,
                                         input int k, input int max_w, input logic pad_en);
      logic ok;
      ok = (w != 8'd0) && (int'(w) <= max_w);
      if (pad_en) ok = ok && (h != 8'd0);
      else        ok = ok && (int'(h) >= k);
      return ok;
   endfunction

endpackage

// File: rtl/line_buffer_kxk_bank.sv
// One line bank: simple dual-port RAM, one write port and one synchronous
// read port. The read register only updates when rd_en_i is high, so a
// stalled read result stays put even if the array is rewritten behind it.
//   clk        clock
//   wr_en_i    write strobe, wr_addr_i / wr_data_i
//   rd_en_i    read strobe, rd_addr_i; rd_data_o valid one cycle later
// Contents are never reset.
module lb_bank_ram #(
   parameter int DW = 256,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [DW-1:0] rd_data_o
);

   logic [DW-1:0] mem_q [0:(1<<AW)-1];
   logic [DW-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/line_buffer_kxk.sv
// KxK line buffer: raster pixels in, K vertically aligned pixels per column
// out (slice 0 = top/oldest row). Ring of K+1 banks so one row can be
// written while K rows are read.
//   cfg_width/height/valid -> cfg_ready, cfg_error   frame setup (IDLE only)
//   in_data/in_valid -> in_ready                     raster input stream
//   out_data/row/col/last/valid <- out_ready         window column stream
//   busy, done                                       frame status
// Optional: define LINE_BUFFER_PAD_EN for same-padding (H windows, rows
// outside the frame read as zero).
module line_buffer_kxk
   import line_buffer_pkg::*;
#(
   parameter int DWIDTH    = 8,
   parameter int P_CH      = 32,
   parameter int K         = 3,
   parameter int MAX_WIDTH = 224,
   parameter int AWIDTH    = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [7:0]               cfg_width,
   input  logic [7:0]               cfg_height,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   output logic                     cfg_error,
   input  logic [DWIDTH*P_CH-1:0]   in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [K*DWIDTH*P_CH-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               out_row,
   output logic [7:0]               out_col,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done
);

   localparam int NB  = lb_num_banks(K);
   localparam int BW  = lb_beat_w(DWIDTH, P_CH);
   localparam int BPW = $clog2(NB);
`ifdef LINE_BUFFER_PAD_EN
   localparam int   PAD    = lb_pad_rows(K);
   localparam logic PAD_EN = 1'b1;
`else
   localparam int   PAD    = 0;
   localparam logic PAD_EN = 1'b0;
`endif
   // Bank holding source row -PAD, i.e. the top slice of window 0.
   localparam logic [BPW-1:0] BASE0 = BPW'((NB - PAD) % NB);

   lb_state_e        state_q;
   logic             cfg_ready_q, cfg_error_q, busy_q, done_q;
   logic [7:0]       w_q, h_q;
   logic [7:0]       wr_row_q, wr_col_q, win_q, rd_col_q;
   logic [BPW-1:0]   wr_bank_q, rd_base_q;
   logic             v1_q, last1_q;
   logic [7:0]       row1_q, col1_q;
   logic [BPW-1:0]   base1_q;
   logic [K-1:0]     zmask1_q, zmask_d;
   logic             out_valid_q, out_last_q;
   logic [7:0]       out_row_q, out_col_q;
   logic [K*BW-1:0]  out_data_q, out_data_d;
   logic [NB-1:0][BW-1:0] rdata;

   logic [9:0] wr_row_x, win_x, h_x, need_rows;
   logic [8:0] nwin;
   logic       in_hs, wr_last_col, wr_last_px;
   logic       rd_active, readable, rd_ok, rd_issue, out_adv, s1_adv;
   logic       rd_last_col, rd_last_win;

   assign wr_row_x = 10'(wr_row_q);
   assign win_x    = 10'(win_q);
   assign h_x      = 10'(h_q);

`ifdef LINE_BUFFER_PAD_EN
   assign nwin      = 9'(h_q);
   // Window o needs source row min(o+PAD, H-1) complete.
   assign need_rows = (win_x + 10'(PAD + 1) < h_x) ? win_x + 10'(PAD + 1) : h_x;
   always_comb begin
      zmask_d = '0;
      for (int k = 0; k < K; k++)
         zmask_d[k] = (win_x + 10'(k) < 10'(PAD)) || (win_x + 10'(k) >= h_x + 10'(PAD));
   end
`else
   assign nwin      = 9'(h_q) - 9'(K) + 9'd1;
   assign need_rows = win_x + 10'(K);
   assign zmask_d   = '0;
`endif

   // Writer may use the bank of row wr_row only if it lies outside the
   // live window (top row win-PAD, K rows).
   assign in_ready    = ((state_q == ST_FILL) || (state_q == ST_STREAM)) &&
                        (wr_row_x + 10'(PAD) <= win_x + 10'(K));
   assign in_hs       = in_valid && in_ready;
   assign wr_last_col = (wr_col_q == w_q - 8'd1);
   assign wr_last_px  = in_hs && wr_last_col && (wr_row_q == h_q - 8'd1);

   assign rd_active   = (state_q == ST_FILL) || (state_q == ST_STREAM) || (state_q == ST_DRAIN);
   assign readable    = (wr_row_x >= need_rows);
   assign rd_ok       = rd_active && (9'(win_q) < nwin) && readable;
   assign out_adv     = !out_valid_q || out_ready;
   assign s1_adv      = v1_q && out_adv;
   assign rd_issue    = rd_ok && (!v1_q || out_adv);
   assign rd_last_col = (rd_col_q == w_q - 8'd1);
   assign rd_last_win = (9'(win_q) == nwin - 9'd1);

   for (genvar b = 0; b < NB; b++) begin : g_bank
      lb_bank_ram #(.DW(BW), .AW(AWIDTH)) u_bank (
         .clk       (clk),
         .wr_en_i   (in_hs && (wr_bank_q == BPW'(b))),
         .wr_addr_i (AWIDTH'(wr_col_q)),
         .wr_data_i (in_data),
         .rd_en_i   (rd_issue),
         .rd_addr_i (AWIDTH'(rd_col_q)),
         .rd_data_o (rdata[b])
      );
   end

   // Rotate bank outputs so slice k comes from bank (base + k) mod NB.
   always_comb begin
      out_data_d = '0;
      for (int k = 0; k < K; k++)
         if (!zmask1_q[k]) out_data_d[k*BW +: BW] = rdata[BPW'((int'(base1_q) + k) % NB)];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cfg_ready_q <= 1'b0;
         cfg_error_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         w_q         <= '0;
         h_q         <= '0;
      end else begin
         cfg_error_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               cfg_ready_q <= 1'b1;
               if (cfg_valid) begin
                  if (lb_cfg_legal(cfg_width, cfg_height, K, MAX_WIDTH, PAD_EN)) begin
                     state_q     <= ST_FILL;
                     w_q         <= cfg_width;
                     h_q         <= cfg_height;
                     busy_q      <= 1'b1;
                     cfg_ready_q <= 1'b0;
                  end else begin
                     cfg_error_q <= 1'b1;
                  end
               end
            end
            ST_FILL: begin
               // Short padded frames can finish input before row K-1 exists.
               if (wr_last_px) state_q <= ST_DRAIN;
               else if (in_hs && wr_last_col && (wr_row_q == 8'(K - 1))) state_q <= ST_STREAM;
            end
            ST_STREAM: if (wr_last_px) state_q <= ST_DRAIN;
            ST_DRAIN: begin
               if (out_valid_q && out_ready && out_last_q) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q     <= ST_IDLE;
               busy_q      <= 1'b0;
               cfg_ready_q <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_row_q  <= '0;
         wr_col_q  <= '0;
         wr_bank_q <= '0;
         win_q     <= '0;
         rd_col_q  <= '0;
         rd_base_q <= BASE0;
      end else if (state_q == ST_IDLE) begin
         wr_row_q  <= '0;
         wr_col_q  <= '0;
         wr_bank_q <= '0;
         win_q     <= '0;
         rd_col_q  <= '0;
         rd_base_q <= BASE0;
      end else begin
         if (in_hs) begin
            if (wr_last_col) begin
               wr_col_q  <= '0;
               wr_row_q  <= wr_row_q + 8'd1;
               wr_bank_q <= (wr_bank_q == BPW'(NB - 1)) ? '0 : wr_bank_q + 1'b1;
            end else begin
               wr_col_q  <= wr_col_q + 8'd1;
            end
         end
         // The window is released as soon as its last column is read; the
         // bank read register keeps that data if the output stalls.
         if (rd_issue) begin
            if (rd_last_col) begin
               rd_col_q  <= '0;
               win_q     <= win_q + 8'd1;
               rd_base_q <= (rd_base_q == BPW'(NB - 1)) ? '0 : rd_base_q + 1'b1;
            end else begin
               rd_col_q  <= rd_col_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1_q        <= 1'b0;
         row1_q      <= '0;
         col1_q      <= '0;
         last1_q     <= 1'b0;
         base1_q     <= '0;
         zmask1_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         if (rd_issue) begin
            v1_q     <= 1'b1;
            row1_q   <= win_q;
            col1_q   <= rd_col_q;
            last1_q  <= rd_last_win && rd_last_col;
            base1_q  <= rd_base_q;
            zmask1_q <= zmask_d;
         end else if (s1_adv) begin
            v1_q     <= 1'b0;
         end
         if (out_adv) begin
            out_valid_q <= v1_q;
            if (v1_q) begin
               out_data_q <= out_data_d;
               out_row_q  <= row1_q;
               out_col_q  <= col1_q;
               out_last_q <= last1_q;
            end
         end
      end
   end

   assign cfg_ready = cfg_ready_q;
   assign cfg_error = cfg_error_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_row   = out_row_q;
   assign out_col   = out_col_q;
   assign out_last  = out_last_q;

endmodule

// File: doc/line_buffer_kxk.md
Name: line_buffer_kxk

Overview:
- Parametrised successor line buffer for depthwise/standard KxK convolution front-ends. Sits between the feature-map streamer and the KxK MAC array.
- Stores a ring of K+1 line banks, each P_CH channels wide. Emits K vertically aligned pixels per column, so the downstream window shifter only needs horizontal registers.
- Adds over the 3-line generation: a configurable kernel size, full valid/ready backpressure on both sides, config-error checking, row/column tags, and optional same-padding.

Parameters:
- DWIDTH, 8, bits per channel sample
- P_CH, 32, channels per beat
- K, 3, kernel height (odd, 3..7)
- MAX_WIDTH, 224, max feature width in pixels
- AWIDTH, 8, bank address width; must satisfy 2^AWIDTH >= MAX_WIDTH

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cfg_width  in  8  feature width W
- cfg_height  in  8  feature height H
- cfg_valid  in  1  config request
- cfg_ready  out  1  high only in IDLE
- cfg_error  out  1  one-cycle pulse on rejected config
- in_data  in  DWIDTH*P_CH  input pixel, raster order
- in_valid  in  1  input valid
- in_ready  out  1  input accept
- out_data  out  K*DWIDTH*P_CH  slice k holds window row k (k=0 is top/oldest)
- out_valid  out  1  output valid
- out_ready  in  1  downstream accept
- out_row  out  8  window top-row index
- out_col  out  8  column index
- out_last  out  1  final beat of frame
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse in DONE

Behaviour:
- Reset values: cfg_ready=0 during reset, then 1 in IDLE; all other outputs 0; state IDLE. All counters cleared. Bank contents are undefined and never cleared.
- States:
  - IDLE -> FILL on cfg_valid with a legal config; W and H are captured.
  - FILL -> STREAM when row K-1 is fully written.
  - STREAM -> DRAIN when the last input pixel (row H-1, col W-1) is accepted.
  - DRAIN -> DONE when the out_last beat handshakes.
  - DONE -> IDLE after 1 cycle.
- Illegal config: W==0, W>MAX_WIDTH, or H<K (H<1 with PAD_EN). Response: cfg_error pulses for 1 cycle and the block stays in IDLE.
- Writes: input row r goes to bank r mod (K+1), at address = column. A handshake occurs when in_valid && in_ready.
- in_ready rule: high in FILL/STREAM when (rows_written - window_top) <= K, i.e. the target bank is not part of the live window. It is low in IDLE/DRAIN/DONE. Read and write therefore never hit the same bank.
- Window o becomes readable once row o+K-1 is completely written.
- Outputs: banks are read synchronously (1 cycle), then out_data passes through a registered skid stage.
- First out_valid rises exactly 2 cycles after the handshake of pixel (K-1, W-1).
- Throughput: one beat per cycle within a row when out_ready is held high. At most 2 bubble cycles between windows.
- Output hold: while out_valid && !out_ready, out_data, out_row, out_col and out_last hold stable. No beat is ever dropped or duplicated.
- Window count: H-K+1 windows (o = 0..H-K) without PAD_EN. Each window emits W beats with col 0..W-1.
- out_last is high only on window H-K, col W-1.
- Counters are 8-bit. Column wraps W-1 -> 0 and increments the row. Bank pointers wrap K -> 0.
- Simultaneous in/out handshakes in the same cycle are legal and independent.
- cfg_valid outside IDLE is ignored.
- Reset mid-frame: immediate return to IDLE, out_valid=0; partial frame discarded.

Optional Feature:
- Macro: LINE_BUFFER_PAD_EN.
- With the macro defined: same-padding, producing H windows (o = 0..H-1).
  - Window row k maps to source row o+k-(K-1)/2.
  - Any row outside [0, H-1] is driven as all-zero data on that slice.
  - Window o becomes readable when source row min(o+(K-1)/2, H-1) is complete.
  - out_last is on window H-1.
- Without the macro: the behaviour above, with no padding logic synthesised.

Decomposition:
- Package line_buffer_pkg:
  - state encoding (IDLE/FILL/STREAM/DRAIN/DONE)
  - localparams for bank count (K+1), beat width (DWIDTH*P_CH), and pad rows ((K-1)/2)
  - config legality limits
- Sub-module lb_bank_ram: one simple dual-port bank (1 write port, 1 synchronous read port, depth 2^AWIDTH), instantiated K+1 times via generate.

Test Plan:
- K=3, W=4, H=5, both sides always ready, pixel value = {row, col} -> 3 windows x 4 beats = 12 beats. Window 1 col 2 gives slices {1,2}, {2,2}, {3,2}. First out_valid 2 cycles after pixel (2,3). out_last on beat 12. done pulses once.
- Same config, out_ready toggling 1-of-3 cycles -> identical 12-beat sequence, outputs stable while stalled, in_ready falls when the writer reaches the live bank.
- cfg_width=0, then cfg_width=225, then cfg_height=2 with K=3 -> three cfg_error pulses, busy stays 0.
- K=5, W=224, H=7 -> 3 windows x 224 beats, column wrap 223->0, bank pointer wrap verified.
- With LINE_BUFFER_PAD_EN, K=3, W=2, H=3 -> 6 beats. Window 0 slice 0 is zero, window 2 slice 2 is zero, out_last on window 2 col 1.
- Assert reset_n low mid-window-1 -> out_valid and busy drop immediately. A fresh K=3, W=4, H=5 frame afterwards yields the exact 12-beat result.
